router_tile_sequencer: RTL and testbench

- Parametrised control block for the router front-end.
- Decodes host writes to N SRAM banks and sequences one input router plus COL_COUNT weight routers through a multi-pass routing job.
- Gates data pops on joint readiness and drains the systolic array between passes.
- Issues reroute/clear pulses between passes and signals job completion; sits between the host interface and the router/systolic-array datapath.

---
 rtl/router_tile_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_router_tile_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_tile_sequencer.sv
// router_tile_sequencer
// ---------------------
// This block controls the router front-end. It decodes host writes into
// per-bank SRAM write enables. It then runs a multi-pass routing job over one
// input router and COL_COUNT weight routers. Each pass follows the sequence
// ROUTE -> DRAIN -> NEXT. The job ends with a one-cycle DONE state.
//
// Ports
//   i_clk, i_nrst        clock, asynchronous active-low reset
//   i_reg_clear          synchronous clear of all state (wins over everything)
//   i_start              job start pulse (accepted only in IDLE)
//   i_pass_count         passes in the job, sampled at start
//   i_drain_cycles       drain length after each pass, sampled at start
//   i_sram_select        host bank select
//   i_write_en           host write strobe
//   o_sram_write_en      one-hot bank write enables (combinational)
//   o_sel_err            host write dropped: bad select or job running
//   i_ir_ready           input router has data
//   i_wr_ready           per-column weight router ready
//   i_ir_pass_done       input router finished the current pass (pulse)
//   o_ir_en, o_wr_en     router enables
//   o_data_out_en        common pop strobe (one cycle after joint readiness)
//   o_reroute            reroute pulse between passes
//   o_sa_clear           systolic-array clear pulse between passes
//   o_pass_idx           current pass index
//   o_busy               job in progress (ROUTE, DRAIN, NEXT)
//   o_done               job complete pulse
//
// Handshake: a pop is issued only for a cycle in ROUTE where the input router
// and every weight router report ready together, and no pass_done arrives in
// that same cycle. o_data_out_en shows that pop one cycle later.
module router_tile_sequencer #(
    parameter int NUM_SRAM  = 2,
    parameter int COL_COUNT = 4,
    parameter int CNT_W     = 8,
    parameter int SEL_W     = (NUM_SRAM > 1) ? $clog2(NUM_SRAM) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_reg_clear,
    input  logic                 i_start,
    input  logic [CNT_W-1:0]     i_pass_count,
    input  logic [CNT_W-1:0]     i_drain_cycles,
    input  logic [SEL_W-1:0]     i_sram_select,
    input  logic                 i_write_en,
    output logic [NUM_SRAM-1:0]  o_sram_write_en,
    output logic                 o_sel_err,
    input  logic                 i_ir_ready,
    input  logic [COL_COUNT-1:0] i_wr_ready,
    input  logic                 i_ir_pass_done,
    output logic                 o_ir_en,
    output logic [COL_COUNT-1:0] o_wr_en,
    output logic                 o_data_out_en,
    output logic                 o_reroute,
    output logic                 o_sa_clear,
    output logic [CNT_W-1:0]     o_pass_idx,
    output logic                 o_busy,
    output logic                 o_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ROUTE = 3'd1,
        S_DRAIN = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_drain_val;
    logic [CNT_W-1:0] r_drain_left;
    logic [CNT_W-1:0] r_pass_idx;
    logic             r_en;
    logic             r_pop;
    logic             r_next_pulse;
    logic             r_done;

    logic             w_all_ready;
    logic             w_last_pass;
    logic             w_sel_in_range;
    logic             w_host_ok;

    assign w_all_ready = i_ir_ready & (&i_wr_ready);
    // r_pass_cnt is never 0 while a job runs, so this subtraction cannot wrap.
    assign w_last_pass = (r_pass_idx == (r_pass_cnt - 1'b1));

    // Host writes are accepted only while no job is in flight.
    assign w_sel_in_range = (int'(i_sram_select) < NUM_SRAM);
    assign w_host_ok      = w_sel_in_range && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign o_sel_err      = i_write_en & ~w_host_ok;

    always_comb begin
        o_sram_write_en = '0;
        for (int i = 0; i < NUM_SRAM; i++) begin
            if (w_host_ok && i_write_en && (int'(i_sram_select) == i)) begin
                o_sram_write_en[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_pass_count != '0) begin
                        w_next = S_ROUTE;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_ROUTE: begin
                if (i_ir_pass_done) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain_left == '0) begin
                    if (w_last_pass) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_NEXT;
                    end
                end
            end
            S_NEXT:  w_next = S_ROUTE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The output registers are loaded from w_next. This lets enables, pulses
    // and o_done line up with the cycle the FSM spends in the matching state.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state      <= S_IDLE;
            r_pass_cnt   <= '0;
            r_drain_val  <= '0;
            r_drain_left <= '0;
            r_pass_idx   <= '0;
            r_en         <= 1'b0;
            r_pop        <= 1'b0;
            r_next_pulse <= 1'b0;
            r_done       <= 1'b0;
        end else if (i_reg_clear) begin
            r_state      <= S_IDLE;
            r_pass_cnt   <= '0;
            r_drain_val  <= '0;
            r_drain_left <= '0;
            r_pass_idx   <= '0;
            r_en         <= 1'b0;
            r_pop        <= 1'b0;
            r_next_pulse <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_en         <= (w_next == S_ROUTE) || (w_next == S_DRAIN) || (w_next == S_NEXT);
            // When pass_done arrives, the state change takes priority over a pop.
            r_pop        <= (r_state == S_ROUTE) && !i_ir_pass_done && w_all_ready;
            r_next_pulse <= (w_next == S_NEXT);
            r_done       <= (w_next == S_DONE);

            if ((r_state == S_IDLE) && i_start && (i_pass_count != '0)) begin
                r_pass_cnt  <= i_pass_count;
                r_drain_val <= i_drain_cycles;
                r_pass_idx  <= '0;
            end

            if ((r_state == S_ROUTE) && i_ir_pass_done) begin
                r_drain_left <= r_drain_val;
            end else if ((r_state == S_DRAIN) && (r_drain_left != '0)) begin
                r_drain_left <= r_drain_left - 1'b1;
            end

            if (r_state == S_NEXT) begin
                r_pass_idx <= r_pass_idx + 1'b1;
            end
        end
    end

    assign o_ir_en       = r_en;
    assign o_wr_en       = {COL_COUNT{r_en}};
    assign o_busy        = r_en;
    assign o_data_out_en = r_pop;
    assign o_reroute     = r_next_pulse;
    assign o_sa_clear    = r_next_pulse;
    assign o_pass_idx    = r_pass_idx;
    assign o_done        = r_done;

endmodule

// File: tb/tb_router_tile_sequencer.sv
// Testbench for router_tile_sequencer. It keeps a job-level behavioural model
// (phase, pass index, drain countdown) and compares every output on every
// cycle. Directed sequences add literal expectations taken from hand-worked
// timing. A second instance with NUM_SRAM=3 covers out-of-range bank selects.
module tb_router_tile_sequencer;

  localparam int P_IDLE  = 0;
  localparam int P_ROUTE = 1;
  localparam int P_DRAIN = 2;
  localparam int P_NEXT  = 3;
  localparam int P_DONE  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic       reg_clear = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pass_count = '0;
  logic [7:0] drain_cycles = '0;
  logic [0:0] sram_select = '0;
  logic       write_en = 1'b0;
  logic       ir_ready = 1'b0;
  logic [3:0] wr_ready = '0;
  logic       ir_pass_done = 1'b0;

  logic [1:0] o_sram_write_en;
  logic       o_sel_err;
  logic       o_ir_en;
  logic [3:0] o_wr_en;
  logic       o_data_out_en;
  logic       o_reroute;
  logic       o_sa_clear;
  logic [7:0] o_pass_idx;
  logic       o_busy;
  logic       o_done;

  logic [1:0] sel3 = '0;
  logic       we3 = 1'b0;
  logic [2:0] wen3;
  logic       err3;
  logic       d3_ir_en, d3_dout, d3_rr, d3_sac, d3_busy, d3_done;
  logic [3:0] d3_wr_en;
  logic [7:0] d3_idx;

  router_tile_sequencer u_dut (
    .i_clk(clk), .i_nrst(nrst), .i_reg_clear(reg_clear), .i_start(start),
    .i_pass_count(pass_count), .i_drain_cycles(drain_cycles),
    .i_sram_select(sram_select), .i_write_en(write_en),
    .o_sram_write_en(o_sram_write_en), .o_sel_err(o_sel_err),
    .i_ir_ready(ir_ready), .i_wr_ready(wr_ready), .i_ir_pass_done(ir_pass_done),
    .o_ir_en(o_ir_en), .o_wr_en(o_wr_en), .o_data_out_en(o_data_out_en),
    .o_reroute(o_reroute), .o_sa_clear(o_sa_clear), .o_pass_idx(o_pass_idx),
    .o_busy(o_busy), .o_done(o_done)
  );

  router_tile_sequencer #(.NUM_SRAM(3)) u_dut3 (
    .i_clk(clk), .i_nrst(nrst), .i_reg_clear(1'b0), .i_start(1'b0),
    .i_pass_count(8'd0), .i_drain_cycles(8'd0),
    .i_sram_select(sel3), .i_write_en(we3),
    .o_sram_write_en(wen3), .o_sel_err(err3),
    .i_ir_ready(1'b0), .i_wr_ready(4'h0), .i_ir_pass_done(1'b0),
    .o_ir_en(d3_ir_en), .o_wr_en(d3_wr_en), .o_data_out_en(d3_dout),
    .o_reroute(d3_rr), .o_sa_clear(d3_sac), .o_pass_idx(d3_idx),
    .o_busy(d3_busy), .o_done(d3_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: job phase plus counters, advanced once per clock
  int m_ph = P_IDLE;
  int m_idx = 0;
  int m_pc = 0;
  int m_dr = 0;
  int m_left = 0;
  bit m_pop = 1'b0;
  int m_job_id = 0;
  int m_job_pc = 0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst || reg_clear) begin
      m_ph = P_IDLE; m_idx = 0; m_pc = 0; m_dr = 0; m_left = 0; m_pop = 1'b0;
    end else begin
      m_pop = 1'b0;
      case (m_ph)
        P_IDLE: if (start) begin
          m_job_id++;
          m_job_pc = int'(pass_count);
          if (pass_count != 0) begin
            m_pc = int'(pass_count); m_dr = int'(drain_cycles); m_idx = 0; m_ph = P_ROUTE;
          end else m_ph = P_DONE;
        end
        P_ROUTE: if (ir_pass_done) begin
          m_left = m_dr; m_ph = P_DRAIN;
        end else m_pop = ir_ready && (wr_ready == 4'hF);
        P_DRAIN: if (m_left == 0) m_ph = (m_idx == m_pc - 1) ? P_DONE : P_NEXT;
                 else m_left--;
        P_NEXT: begin m_idx++; m_ph = P_ROUTE; end
        default: m_ph = P_IDLE;
      endcase
    end
  end

  // scoreboard / compare process
  int tot_rr = 0;
  int tot_done = 0;
  int job_rr = 0;
  int seen_job = 0;

  initial forever begin
    bit e_en, host_ok;
    logic [1:0] e_wen;
    @(posedge clk); #3;
    e_en = (m_ph == P_ROUTE) || (m_ph == P_DRAIN) || (m_ph == P_NEXT);
    host_ok = (m_ph == P_IDLE) || (m_ph == P_DONE);
    e_wen = (write_en && host_ok) ? (2'b01 << sram_select) : 2'b00;
    check("cyc_ir_en", o_ir_en, e_en);
    check("cyc_wr_en", o_wr_en, {4{e_en}});
    check("cyc_busy", o_busy, e_en);
    check("cyc_pop", o_data_out_en, m_pop);
    check("cyc_reroute", o_reroute, m_ph == P_NEXT);
    check("cyc_sa_clear", o_sa_clear, m_ph == P_NEXT);
    check("cyc_done", o_done, m_ph == P_DONE);
    check("cyc_idx", o_pass_idx, m_idx[7:0]);
    check("cyc_wen", o_sram_write_en, e_wen);
    check("cyc_err", o_sel_err, write_en && !host_ok);
    if (seen_job != m_job_id) begin seen_job = m_job_id; job_rr = 0; end
    if (o_reroute) begin job_rr++; tot_rr++; end
    if (o_done) begin
      tot_done++;
      check("rr_per_job", job_rr, (m_job_pc == 0) ? 0 : m_job_pc - 1);
    end
  end

  // driver tasks
  task automatic start_job(input int pc, input int dr);
    start = 1'b1; pass_count = 8'(pc); drain_cycles = 8'(dr);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    while (!o_done && cycles < limit) begin cycles++; @(negedge clk); end
    if (!o_done) check("wait_done_timeout", 0, 1);
  endtask

  initial begin
    int d, w, rr0, d0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_idx", o_pass_idx, 0);
    check("rst_done", o_done, 0);

    // host write decode
    write_en = 1'b1; sram_select = 1'b0; #1;
    check("wen_sel0", o_sram_write_en, 2'b01);
    sram_select = 1'b1; #1;
    check("wen_sel1", o_sram_write_en, 2'b10);
    check("err_sel1", o_sel_err, 0);
    we3 = 1'b1; sel3 = 2'd2; #1;
    check("wen3_sel2", wen3, 3'b100);
    sel3 = 2'd3; #1;
    check("wen3_sel3", wen3, 3'b000);
    check("err3_sel3", err3, 1);
    @(negedge clk);
    write_en = 1'b0; we3 = 1'b0;

    // single pass, drain 2
    rr0 = tot_rr;
    start_job(1, 2);
    check("ir_en_after_start", o_ir_en, 1);
    check("wr_en_after_start", o_wr_en, 4'hF);
    ir_ready = 1'b1; wr_ready = 4'hF;
    @(negedge clk);
    check("pop_all_ready", o_data_out_en, 1);
    start = 1'b1; pass_count = 8'd5; write_en = 1'b1; sram_select = 1'b0; wr_ready = 4'hE; #1;
    check("busy_wen", o_sram_write_en, 2'b00);
    check("busy_err", o_sel_err, 1);
    @(negedge clk);
    start = 1'b0; write_en = 1'b0;
    check("pop_one_low", o_data_out_en, 0);
    wr_ready = 4'hF; ir_pass_done = 1'b1;
    @(negedge clk);
    ir_pass_done = 1'b0;
    check("pop_vs_done", o_data_out_en, 0);
    wait_done(20, d);
    check("drain_len_2", d, 3);
    check("done_single", o_done, 1);
    check("rr_single", tot_rr - rr0, 0);
    @(negedge clk);
    check("done_one_cycle", o_done, 0);
    check("busy_after", o_busy, 0);

    // three passes, drain 0
    rr0 = tot_rr; d0 = tot_done;
    start_job(3, 0);
    for (int p = 0; p < 3; p++) begin
      check("idx_step", o_pass_idx, p);
      repeat (2) @(negedge clk);
      ir_pass_done = 1'b1;
      @(negedge clk);
      ir_pass_done = 1'b0;
      check("pop_vs_done3", o_data_out_en, 0);
      w = 0;
      while (!(o_reroute || o_done) && w < 10) begin w++; @(negedge clk); end
      check("drain_len_0", w, 1);
      if (p < 2) begin
        check("reroute_pulse", o_reroute, 1);
        check("sa_clear_pulse", o_sa_clear, 1);
        @(negedge clk);
        check("reroute_one_cycle", o_reroute, 0);
      end else begin
        check("done_three", o_done, 1);
        @(negedge clk);
      end
    end
    check("rr_three", tot_rr - rr0, 2);
    check("done_cnt_three", tot_done - d0, 1);

    // zero passes
    start_job(0, 3);
    check("zero_done", o_done, 1);
    check("zero_busy", o_busy, 0);
    check("zero_ir_en", o_ir_en, 0);
    @(negedge clk);
    check("zero_done_gone", o_done, 0);

    // abort by clear during DRAIN
    start_job(2, 5);
    repeat (2) @(negedge clk);
    ir_pass_done = 1'b1;
    @(negedge clk);
    ir_pass_done = 1'b0;
    @(negedge clk);
    reg_clear = 1'b1; #1;
    check("clear_is_sync", o_busy, 1);
    @(negedge clk);
    reg_clear = 1'b0;
    check("clear_busy", o_busy, 0);
    check("clear_ir_en", o_ir_en, 0);
    check("clear_idx", o_pass_idx, 0);
    d0 = tot_done;
    repeat (8) @(negedge clk);
    check("no_done_after_clear", tot_done - d0, 0);

    // abort by async reset during ROUTE
    start_job(1, 1);
    @(negedge clk);
    #2 nrst = 1'b0; #1;
    check("rst_ir_en", o_ir_en, 0);
    check("rst_wr_en", o_wr_en, 0);
    check("rst_pop", o_data_out_en, 0);
    check("rst_busy_mid", o_busy, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    d0 = tot_done;
    start_job(1, 0);
    check("restart_ir_en", o_ir_en, 1);
    ir_pass_done = 1'b1;
    @(negedge clk);
    ir_pass_done = 1'b0;
    wait_done(10, d);
    check("restart_drain", d, 1);
    check("restart_done_cnt", tot_done - d0, 1);
    @(negedge clk);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      start        = ($urandom_range(0, 15) == 0);
      pass_count   = 8'($urandom_range(0, 4));
      drain_cycles = 8'($urandom_range(0, 3));
      ir_ready     = ($urandom_range(0, 3) != 0);
      wr_ready     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      ir_pass_done = ($urandom_range(0, 5) == 0);
      write_en     = ($urandom_range(0, 3) == 0);
      sram_select  = 1'($urandom_range(0, 1));
      reg_clear    = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    start = 1'b0; ir_pass_done = 1'b0; write_en = 1'b0; reg_clear = 1'b0;
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
